mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter that lets the CPU instruction port (IP, read-only) and data port (DP, read/write) share one unified 16-bit memory slave. It sits between MainCPU and a single memory model, using the same Trans/Ready transaction handshake on every side. DP has fixed priority, with a streak limit so IP fetches are never starved.

Parameters:
AW, 16, address width of all address buses
DW, 16, data width of all data buses
MAX_DP_STREAK, 4, max consecutive DP grants while IP is pending; then IP is granted once
TIMEOUT_CYCLES, 255, slave-wait limit in BUSY (used only with ARB_TIMEOUT_EN)

Ports:
Clk  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-low reset
IPTrans  in  1  IP request, held high until IPReady sampled
IPAdressBus  in  AW  IP address
IPReadBus  out  DW  IP read data, valid when IPReady=1
IPReady  out  1  one-cycle completion pulse to IP
DPTrans  in  1  DP request, held high until DPReady sampled
DPReadWrite  in  1  0=read, 1=write
DPAdressBus  in  AW  DP address
DPWriteBus  in  DW  DP write data
DPReadBus  out  DW  DP read data, valid when DPReady=1
DPReady  out  1  one-cycle completion pulse to DP
MemTrans  out  1  request to slave
MemReadWrite  out  1  0=read, 1=write
MemAdressBus  out  AW  slave address
MemWriteBus  out  DW  slave write data
MemReadBus  in  DW  slave read data, valid with MemReady
MemReady  in  1  slave completion pulse
GrantDP  out  1  1 while the current/last transaction owner is DP
BusErr  out  1  one-cycle timeout error pulse, coincident with the Ready pulse

Behaviour:
- All outputs are registered. Reset (RST=0 at an edge) forces: state IDLE, all outputs 0, streak counter 0, latches 0.
- Reset mid-transaction abandons the transfer. No Ready is returned. A MemReady arriving after reset is ignored.
- FSM states are IDLE, BUSY and RESP.
- IDLE -> BUSY happens when IPTrans or DPTrans is high:
  - Grant DP if DPTrans=1, unless IPTrans=1 and streak==MAX_DP_STREAK; otherwise grant IP.
  - At this edge, latch the winner's address, write data and rw (IP rw is forced to 0) onto the Mem* outputs, set MemTrans=1, and set GrantDP.
  - Streak counter: +1 on a DP grant while IPTrans=1 (saturating). Cleared on an IP grant or when IPTrans=0.
- BUSY holds Mem* stable until MemReady=1 is sampled. At that edge:
  - MemTrans goes 0.
  - For a read, MemReadBus is captured into the owner's ReadBus.
  - The owner's Ready goes to 1; state -> RESP.
- RESP lasts exactly one cycle: Ready=1, then Ready returns to 0 and state -> IDLE.
  - Both masters' Trans are ignored during RESP.
  - A master may re-request immediately; it is sampled in IDLE on the next edge.
- Minimum latency: request sampled at edge 0, MemTrans high from edge 0. A slave answering at edge k gives master Ready high from edge k for one cycle. Minimum cost is 3 cycles per transfer.
- The non-owner's Ready and ReadBus never change. Each ReadBus holds its last value until its next read.
- Writes leave the owner's ReadBus unchanged.
- MemReady in IDLE or RESP is ignored.
- Simultaneous requests in IDLE follow the priority rule above. The loser keeps Trans high and is served later.
- Addresses pass through unmodified. No range decoding; the console location 1023 is an ordinary address.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no MemReady, MemTrans goes 0 and state -> RESP.
  - The owner gets Ready=1 with ReadBus=16'hDEAD (read or write), and BusErr=1 for that one cycle.
  - A MemReady arriving on the timeout edge wins: normal completion, no error.
- Undefined: BUSY waits indefinitely, no counter logic is present, and BusErr is tied to 0.

Test Plan:
1. Reset: hold RST=0 for 3 cycles with requests active -> all outputs 0; no MemTrans until RST=1.
2. IP read of address 5 holding 16'h0041, slave Ready latency 2 -> MemAdressBus=5, MemReadWrite=0; IPReady one cycle with IPReadBus=16'h0041; DPReady stays 0.
3. DP write of 16'h0068 to address 1023 -> MemReadWrite=1, MemWriteBus=16'h0068; DPReady one cycle; memory[1023]=16'h0068; DPReadBus unchanged.
4. IP and DP raise Trans on the same cycle -> DP served first (GrantDP=1), IP served next; exactly one Ready pulse each.
5. DP requests back-to-back continuously while IP is pending, MAX_DP_STREAK=4 -> grant order DP,DP,DP,DP,IP,DP...; IP wait is bounded.
6. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never answers a DP read -> DPReady and BusErr pulse together 8 BUSY cycles after grant, DPReadBus=16'hDEAD; the next request proceeds normally. Assert RST=0 during a later BUSY -> no Ready pulse; state IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (CPU instruction port IP, data port DP), one-slave
// arbiter sharing a unified memory over the Trans/Ready handshake.
// DP has fixed priority, but after MAX_DP_STREAK back-to-back DP grants with IP
// waiting, IP is granted once so instruction fetches cannot starve.
// Optional build macro ARB_TIMEOUT_EN adds a slave-wait timeout in BUSY that
// completes the transfer with read data 16'hDEAD and a BusErr pulse.
module mem_bus_arbiter #(
  parameter int unsigned AW             = 16,
  parameter int unsigned DW             = 16,
  parameter int unsigned MAX_DP_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          Clk,
  input  logic          RST,
  // Instruction port (read-only master)
  input  logic          IPTrans,
  input  logic [AW-1:0] IPAdressBus,
  output logic [DW-1:0] IPReadBus,
  output logic          IPReady,
  // Data port (read/write master)
  input  logic          DPTrans,
  input  logic          DPReadWrite,
  input  logic [AW-1:0] DPAdressBus,
  input  logic [DW-1:0] DPWriteBus,
  output logic [DW-1:0] DPReadBus,
  output logic          DPReady,
  // Memory slave side
  output logic          MemTrans,
  output logic          MemReadWrite,
  output logic [AW-1:0] MemAdressBus,
  output logic [DW-1:0] MemWriteBus,
  input  logic [DW-1:0] MemReadBus,
  input  logic          MemReady,
  // Status
  output logic          GrantDP,
  output logic          BusErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned SW = $clog2(MAX_DP_STREAK + 1);

  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_trans_q, mem_trans_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          grant_dp_q, grant_dp_d;
  logic [DW-1:0] ip_rdata_q, ip_rdata_d;
  logic [DW-1:0] dp_rdata_q, dp_rdata_d;
  logic          ip_ready_q, ip_ready_d;
  logic          dp_ready_q, dp_ready_d;
  logic          dp_wins;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] ErrData = DW'(16'hDEAD);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            berr_q, berr_d;
`endif

  // DP wins unless IP is waiting and DP has already used up its streak.
  assign dp_wins = DPTrans && !(IPTrans && (streak_q == SW'(MAX_DP_STREAK)));

  // Next-state: arbitration in IDLE, slave wait in BUSY, one-cycle Ready in RESP.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_trans_d = mem_trans_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_dp_d  = grant_dp_q;
    ip_rdata_d  = ip_rdata_q;
    dp_rdata_d  = dp_rdata_q;
    ip_ready_d  = 1'b0;
    dp_ready_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    berr_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (IPTrans || DPTrans) begin
          state_d     = BUSY;
          mem_trans_d = 1'b1;
          grant_dp_d  = dp_wins;
          if (dp_wins) begin
            mem_addr_d  = DPAdressBus;
            mem_wdata_d = DPWriteBus;
            mem_rw_d    = DPReadWrite;
          end else begin
            mem_addr_d  = IPAdressBus;
            mem_wdata_d = '0;
            mem_rw_d    = 1'b0;
          end
          // Streak only counts DP grants that made IP wait.
          if (dp_wins && IPTrans) begin
            if (streak_q != SW'(MAX_DP_STREAK)) streak_d = streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
`ifdef ARB_TIMEOUT_EN
          tmo_d = '0;
`endif
        end else begin
          streak_d = '0;
        end
      end
      BUSY: begin
        if (MemReady) begin
          mem_trans_d = 1'b0;
          state_d     = RESP;
          if (grant_dp_q) begin
            dp_ready_d = 1'b1;
            if (!mem_rw_q) dp_rdata_d = MemReadBus;
          end else begin
            ip_ready_d = 1'b1;
            if (!mem_rw_q) ip_rdata_d = MemReadBus;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // A MemReady on the same edge takes the branch above: no error.
        else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          mem_trans_d = 1'b0;
          state_d     = RESP;
          berr_d      = 1'b1;
          if (grant_dp_q) begin
            dp_ready_d = 1'b1;
            dp_rdata_d = ErrData;
          end else begin
            ip_ready_d = 1'b1;
            ip_rdata_d = ErrData;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!RST) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_trans_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_dp_q  <= 1'b0;
      ip_rdata_q  <= '0;
      dp_rdata_q  <= '0;
      ip_ready_q  <= 1'b0;
      dp_ready_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= '0;
      berr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_trans_q <= mem_trans_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_dp_q  <= grant_dp_d;
      ip_rdata_q  <= ip_rdata_d;
      dp_rdata_q  <= dp_rdata_d;
      ip_ready_q  <= ip_ready_d;
      dp_ready_q  <= dp_ready_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      berr_q      <= berr_d;
`endif
    end
  end

  assign IPReadBus    = ip_rdata_q;
  assign IPReady      = ip_ready_q;
  assign DPReadBus    = dp_rdata_q;
  assign DPReady      = dp_ready_q;
  assign MemTrans     = mem_trans_q;
  assign MemReadWrite = mem_rw_q;
  assign MemAdressBus = mem_addr_q;
  assign MemWriteBus  = mem_wdata_q;
  assign GrantDP      = grant_dp_q;
`ifdef ARB_TIMEOUT_EN
  assign BusErr       = berr_q;
`else
  assign BusErr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned MaxStreak     = 4;
  localparam int unsigned TimeoutCycles = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ip_trans, ip_ready, dp_trans, dp_rw, dp_ready;
  logic [15:0] ip_addr, ip_rdata, dp_addr, dp_wdata, dp_rdata;
  logic        mem_trans, mem_rw, mem_ready, grant_dp, bus_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW            (16),
    .DW            (16),
    .MAX_DP_STREAK (MaxStreak),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) u_dut (
    .Clk         (clk),
    .RST         (rst_n),
    .IPTrans     (ip_trans),
    .IPAdressBus (ip_addr),
    .IPReadBus   (ip_rdata),
    .IPReady     (ip_ready),
    .DPTrans     (dp_trans),
    .DPReadWrite (dp_rw),
    .DPAdressBus (dp_addr),
    .DPWriteBus  (dp_wdata),
    .DPReadBus   (dp_rdata),
    .DPReady     (dp_ready),
    .MemTrans    (mem_trans),
    .MemReadWrite(mem_rw),
    .MemAdressBus(mem_addr),
    .MemWriteBus (mem_wdata),
    .MemReadBus  (mem_rdata),
    .MemReady    (mem_ready),
    .GrantDP     (grant_dp),
    .BusErr      (bus_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference memories: the slave acts on the DUT bus, the model on its own view.
  logic [15:0] ref_mem   [65536];
  logic [15:0] slave_mem [65536];

  // Reference model: 0 = free, 1 = transfer outstanding, 2 = answer being shown.
  int          m_phase, m_streak, m_wait;
  bit          m_dp, m_rw;
  logic [15:0] m_addr, m_wd;
  bit          e_trans, e_grant, e_ip_rdy, e_dp_rdy, e_err;
  logic [15:0] e_ip_rd, e_dp_rd;

  // Bench-side bookkeeping
  int  cyc = 0;
  bit  prev_trans = 1'b0;
  bit  obs_grants[$];
  bit  served[$];
  int  ip_rate = 0, dp_rate = 0;
  bit  slave_mute = 1'b0;
  bit  slv_active = 1'b0;
  int  slv_cnt = 0;
  int  slv_fixed = -1;

  function automatic logic [15:0] rand_addr();
    int a = int'($urandom_range(0, 8));
    return (a == 8) ? 16'd1023 : 16'(a);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_wait = 0; m_dp = 0; m_rw = 0; m_addr = '0; m_wd = '0;
    e_trans = 0; e_grant = 0; e_ip_rdy = 0; e_dp_rdy = 0; e_err = 0;
    e_ip_rd = '0; e_dp_rd = '0;
  endtask

  task automatic model_finish(input bit err);
    logic [15:0] data;
    data = err ? 16'hDEAD : ref_mem[m_addr];
    if (!err && m_rw) ref_mem[m_addr] = m_wd;
    if (m_dp) begin
      e_dp_rdy = 1;
      if (err || !m_rw) e_dp_rd = data;
    end else begin
      e_ip_rdy = 1;
      if (err || !m_rw) e_ip_rd = data;
    end
    e_err   = err;
    e_trans = 0;
    m_phase = 2;
  endtask

  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_edge();
    bit dp_first;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_ip_rdy = 0; e_dp_rdy = 0; e_err = 0;
    if (m_phase == 0) begin
      if (ip_trans || dp_trans) begin
        dp_first = dp_trans && !(ip_trans && m_streak >= int'(MaxStreak));
        m_dp     = dp_first;
        m_addr   = dp_first ? dp_addr : ip_addr;
        m_rw     = dp_first ? dp_rw : 1'b0;
        m_wd     = dp_first ? dp_wdata : 16'h0;
        if (dp_first && ip_trans) m_streak = (m_streak < int'(MaxStreak)) ? m_streak + 1 : m_streak;
        else m_streak = 0;
        m_wait  = 0;
        e_trans = 1;
        e_grant = dp_first;
        m_phase = 1;
      end else begin
        m_streak = 0;
      end
    end else if (m_phase == 1) begin
      m_wait++;
      if (mem_ready) model_finish(1'b0);
      else if (TmoEn && m_wait == int'(TimeoutCycles)) model_finish(1'b1);
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_all();
    check_eq("ip_ready", ip_ready, e_ip_rdy);
    check_eq("dp_ready", dp_ready, e_dp_rdy);
    check_eq("ip_rdata", ip_rdata, e_ip_rd);
    check_eq("dp_rdata", dp_rdata, e_dp_rd);
    check_eq("mem_trans", mem_trans, e_trans);
    check_eq("mem_rw", mem_rw, m_rw);
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_wdata", mem_wdata, m_wd);
    check_eq("grant_dp", grant_dp, e_grant);
    check_eq("bus_err", bus_err, e_err);
  endtask

  // Slave: answers after a random delay, sprinkles stray MemReady while the bus is idle.
  task automatic slave_drive();
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
    if (mem_trans && !slave_mute) begin
      if (!slv_active) begin
        slv_active = 1'b1;
        slv_cnt = (slv_fixed >= 0) ? slv_fixed : int'($urandom_range(0, 3));
      end
      if (slv_cnt == 0) begin
        mem_ready  = 1'b1;
        mem_rdata  = slave_mem[mem_addr];
        if (mem_rw) slave_mem[mem_addr] = mem_wdata;
        slv_active = 1'b0;
      end else begin
        slv_cnt--;
      end
    end else if (!mem_trans) begin
      slv_active = 1'b0;
      if ($urandom_range(0, 7) == 0) mem_ready = 1'b1;
    end
  endtask

  task automatic drive_masters();
    if (ip_trans && ip_ready) ip_trans = 1'b0;
    if (dp_trans && dp_ready) dp_trans = 1'b0;
    if (!ip_trans && int'($urandom_range(0, 99)) < ip_rate) begin
      ip_trans = 1'b1;
      ip_addr  = rand_addr();
    end
    if (!dp_trans && int'($urandom_range(0, 99)) < dp_rate) begin
      dp_trans = 1'b1;
      dp_addr  = rand_addr();
      dp_rw    = 1'($urandom_range(0, 1));
      dp_wdata = 16'($urandom);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (mem_trans && !prev_trans) obs_grants.push_back(grant_dp);
    prev_trans = mem_trans;
    if (ip_ready) served.push_back(1'b0);
    if (dp_ready) served.push_back(1'b1);
    check_all();
    slave_drive();
    drive_masters();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : main
    bit          exp5 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] dp_before;
    int          start_cyc, done_cyc, g_cyc, r_cyc;
    bit          err_seen;

    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]   = 16'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[5] = 16'h0041;
    slave_mem[5] = 16'h0041;
    model_reset();

    // 1: reset held with both masters requesting
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    ip_trans = 1'b1; ip_addr = 16'd3;
    dp_trans = 1'b1; dp_rw = 1'b0; dp_addr = 16'd4; dp_wdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t1_memtrans_in_reset", mem_trans, 1'b0);
    end
    ip_trans = 1'b0; dp_trans = 1'b0;
    rst_n = 1'b1;
    steps(2);

    // 2: IP read of address 5, slave answers on the second edge
    slv_fixed = 1;
    served.delete(); obs_grants.delete();
    ip_trans = 1'b1; ip_addr = 16'd5;
    steps(10);
    check_eq("t2_served", served.size(), 1);
    check_eq("t2_owner", served[0], 1'b0);
    check_eq("t2_ipdata", ip_rdata, 16'h0041);
    check_eq("t2_memaddr", mem_addr, 16'd5);
    check_eq("t2_memrw", mem_rw, 1'b0);

    // 3: DP write to the console location
    served.delete();
    dp_before = dp_rdata;
    dp_trans = 1'b1; dp_rw = 1'b1; dp_addr = 16'd1023; dp_wdata = 16'h0068;
    steps(10);
    check_eq("t3_served", served.size(), 1);
    check_eq("t3_owner", served[0], 1'b1);
    check_eq("t3_memrw", mem_rw, 1'b1);
    check_eq("t3_memwdata", mem_wdata, 16'h0068);
    check_eq("t3_slave_mem", slave_mem[1023], 16'h0068);
    check_eq("t3_dprdata_kept", dp_rdata, dp_before);
    slv_fixed = -1;

    // 4: simultaneous requests
    served.delete(); obs_grants.delete();
    ip_trans = 1'b1; ip_addr = 16'd2;
    dp_trans = 1'b1; dp_rw = 1'b0; dp_addr = 16'd3;
    steps(20);
    check_eq("t4_grants", obs_grants.size(), 2);
    check_eq("t4_first_dp", obs_grants[0], 1'b1);
    check_eq("t4_second_ip", obs_grants[1], 1'b0);
    check_eq("t4_served", served.size(), 2);

`ifdef ARB_TIMEOUT_EN
    // 6: slave never answers a DP read
    slave_mute = 1'b1;
    served.delete();
    g_cyc = 0; r_cyc = 0; err_seen = 1'b0;
    dp_trans = 1'b1; dp_rw = 1'b0; dp_addr = 16'd7;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_trans && g_cyc == 0) g_cyc = cyc;
      if (dp_ready && r_cyc == 0) begin
        r_cyc = cyc;
        err_seen = bus_err;
      end
    end
    check_eq("t6_timeout_delay", r_cyc - g_cyc, TimeoutCycles);
    check_eq("t6_buserr", err_seen, 1'b1);
    check_eq("t6_dead", dp_rdata, 16'hDEAD);
    slave_mute = 1'b0;
    ip_trans = 1'b1; ip_addr = 16'd5;
    steps(12);
    check_eq("t6_after_ipdata", ip_rdata, 16'h0041);
    check_eq("t6_after_served", served.size(), 2);
`endif

    // 7: reset in the middle of a stalled transfer
    slave_mute = 1'b1;
    served.delete();
    dp_trans = 1'b1; dp_rw = 1'b0; dp_addr = 16'd6;
    steps(3);
    check_eq("t7_busy", mem_trans, 1'b1);
    rst_n = 1'b0;
    steps(2);
    check_eq("t7_trans_cleared", mem_trans, 1'b0);
    dp_trans = 1'b0; slave_mute = 1'b0;
    rst_n = 1'b1;
    step();
    mem_ready = 1'b1;
    steps(3);
    check_eq("t7_no_ready", served.size(), 0);

    // 5: DP keeps re-requesting while IP waits
    served.delete(); obs_grants.delete();
    dp_rate = 100;
    ip_trans = 1'b1; ip_addr = 16'd4;
    dp_trans = 1'b1; dp_rw = 1'b0; dp_addr = 16'd1;
    start_cyc = cyc; done_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done_cyc == 0 && served.size() > 0 && served[served.size() - 1] == 1'b0) done_cyc = cyc;
    end
    check_eq("t5_grant_count_ok", obs_grants.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t5_grant%0d", i), obs_grants[i], exp5[i]);
    check_eq("t5_ip_wait_bounded", (done_cyc > 0) && (done_cyc - start_cyc <= 40), 1'b1);
    dp_rate = 0;
    steps(10);

    // Random traffic
    ip_rate = 30; dp_rate = 30;
    steps(1500);
    ip_rate = 0; dp_rate = 0;
    steps(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
